// File: rtl/stack_access_ctrl_pkg.sv
// Shared constants for the CALL/RET stack sequencer.
// SP op codes must match the stackPointer decoder.
package stack_access_ctrl_pkg;

  localparam logic [1:0] SP_DEF  = 2'b00;
  localparam logic [1:0] SP_POP  = 2'b01;
  localparam logic [1:0] SP_PUSH = 2'b10;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH_WR  = 3'd1;
  localparam logic [2:0] S_POP_RD   = 3'd2;
  localparam logic [2:0] S_POP_WAIT = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

endpackage

// File: rtl/stack_access_ctrl.sv
// CALL/RET stack sequencer: drives stackPointer op, data-memory
// strobes and a valid/ready response. Bounds checked against raw SP.
module stack_access_ctrl
  import stack_access_ctrl_pkg::*;
#(
  parameter int STACK_BASE  = 222,
  parameter int STACK_LIMIT = 256,
  parameter int DW          = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_push,
  input  logic [DW-1:0] req_data,
  input  logic [DW-1:0] sp,
  output logic [1:0]    sp_op,
  output logic [DW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          ovf_sticky,
  output logic          udf_sticky
);

  localparam logic [DW-1:0] LP_BASE  = DW'(STACK_BASE);
  localparam logic [DW-1:0] LP_LIMIT = DW'(STACK_LIMIT);
  localparam logic [DW-1:0] LP_ONE   = DW'(1);

  logic [2:0]    r_state;
  logic [1:0]    r_sp_op;
  logic [DW-1:0] r_addr;
  logic          r_wr_en;
  logic          r_rd_en;
  logic [DW-1:0] r_wdata;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_err;
  logic          r_ovf;
  logic          r_udf;

  logic          w_ovf;
  logic          w_udf;
  logic [DW-1:0] w_sp_dec;

  assign w_ovf    = sp >= LP_LIMIT;
  assign w_udf    = sp <= LP_BASE;
  assign w_sp_dec = sp - LP_ONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sp_op     <= SP_DEF;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            // Errors skip memory and SP entirely
            if (req_push && w_ovf) begin
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
              r_ovf       <= 1'b1;
              r_state     <= S_RESP;
            end else if (!req_push && w_udf) begin
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
              r_udf       <= 1'b1;
              r_state     <= S_RESP;
            end else if (req_push) begin
              r_wr_en <= 1'b1;
              r_addr  <= sp;
              r_wdata <= req_data;
              r_sp_op <= SP_PUSH;
              r_state <= S_PUSH_WR;
            end else begin
              r_rd_en <= 1'b1;
              r_addr  <= w_sp_dec;
              r_sp_op <= SP_POP;
              r_state <= S_POP_RD;
            end
          end
        end
        S_PUSH_WR: begin
          r_wr_en     <= 1'b0;
          r_sp_op     <= SP_DEF;
          r_rsp_data  <= '0;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_POP_RD: begin
          r_rd_en <= 1'b0;
          r_sp_op <= SP_DEF;
          r_state <= S_POP_WAIT;
        end
        S_POP_WAIT: begin
          r_rsp_data  <= mem_rdata;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign sp_op      = r_sp_op;
  assign mem_addr   = r_addr;
  assign mem_wr_en  = r_wr_en;
  assign mem_rd_en  = r_rd_en;
  assign mem_wdata  = r_wdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign ovf_sticky = r_ovf;
  assign udf_sticky = r_udf;

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Bench for stack_access_ctrl: queue-based stack model, SP/memory
// environment, scoreboard with an independent response monitor.
module tb_stack_access_ctrl;

  localparam int BASE  = 222;
  localparam int LIMIT = 256;
  localparam int DEPTH = LIMIT - BASE;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_push = 1'b0;
  logic [31:0] req_data = '0;
  logic [31:0] sp = 32'(BASE);
  logic [1:0]  sp_op;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ovf_sticky;
  logic        udf_sticky;

  stack_access_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_push(req_push), .req_data(req_data),
    .sp(sp), .sp_op(sp_op),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  always #5 clock = ~clock;

  // stackPointer and data memory stand-ins
  logic [31:0] mem [0:511];
  int cyc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (sp_op == 2'b10) sp <= sp + 1;
    else if (sp_op == 2'b01) sp <= sp - 1;
    if (mem_wr_en) mem[mem_addr[8:0]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr[8:0]];
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        is_push;
    logic [31:0] wdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mstk[$];
  bit          m_ovf = 0;
  bit          m_udf = 0;
  bit          hold = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: strobe bookkeeping and response checking
  int          n_push = 0, n_pop = 0, n_wr = 0, n_rd = 0;
  logic        p_valid = 0, p_ready = 0, p_err = 0;
  logic [31:0] p_data = '0;
  always @(negedge clock) begin
    if (!reset) begin
      n_push = 0; n_pop = 0; n_wr = 0; n_rd = 0;
      p_valid = 0; p_ready = 0;
    end else begin
      if (sp_op == 2'b10) n_push++;
      if (sp_op == 2'b01) n_pop++;
      if (mem_wr_en) begin
        n_wr++;
        chk("wr_addr", mem_addr, sp);
        if (sbq.size() > 0) chk("wr_data", mem_wdata, sbq[0].wdata);
      end
      if (mem_rd_en) begin
        n_rd++;
        chk("rd_addr", mem_addr, sp - 32'd1);
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got valid expected none");
        end else begin
          if (!p_valid)
            chk("latency", cyc - sbq[0].acc + 1, sbq[0].lat);
          else if (!p_ready) begin
            chk("hold_data", rsp_data, p_data);
            chk("hold_err", rsp_err, p_err);
          end
          if (rsp_ready) begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            chk("push_ops", n_push, (e.is_push && !e.err) ? 1 : 0);
            chk("pop_ops", n_pop, (!e.is_push && !e.err) ? 1 : 0);
            chk("wr_strobes", n_wr, (e.is_push && !e.err) ? 1 : 0);
            chk("rd_strobes", n_rd, (!e.is_push && !e.err) ? 1 : 0);
            chk("ovf_sticky", ovf_sticky, m_ovf);
            chk("udf_sticky", udf_sticky, m_udf);
            chk("sp_depth", sp, 32'(BASE + mstk.size()));
            n_push = 0; n_pop = 0; n_wr = 0; n_rd = 0;
          end
        end
      end
      p_valid = rsp_valid;
      p_ready = rsp_ready;
      p_data  = rsp_data;
      p_err   = rsp_err;
    end
  end

  task automatic do_req(bit push, logic [31:0] d);
    int   n;
    exp_t e;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_push  = push;
    req_data  = d;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      errors++;
      $display("FAIL req_timeout: got ready=0 expected ready=1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    e.acc = cyc; e.is_push = push; e.wdata = d;
    e.data = '0; e.err = 1'b0;
    if (push) begin
      if (mstk.size() >= DEPTH) begin
        e.err = 1'b1; m_ovf = 1; e.lat = 1;
      end else begin
        mstk.push_back(d); e.lat = 2;
      end
    end else begin
      if (mstk.size() == 0) begin
        e.err = 1'b1; m_udf = 1; e.lat = 1;
      end else begin
        e.data = mstk.pop_back(); e.lat = 3;
      end
    end
    sbq.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_sp_op", sp_op, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("init_req_ready", req_ready, 1'b1);
    chk("init_sp_op", sp_op, 2'b00);
    chk("init_rsp_valid", rsp_valid, 1'b0);
    chk("init_strobes", {mem_wr_en, mem_rd_en}, 2'b00);
    chk("init_addr", mem_addr, 32'd0);
    chk("init_sticky", {ovf_sticky, udf_sticky}, 2'b00);

    do_req(1'b1, 32'h0000_1234); drain();
    do_req(1'b0, $urandom);      drain();
    do_req(1'b0, $urandom);      drain();

    // Response held off: outputs must stay put
    hold = 1;
    do_req(1'b1, $urandom);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    repeat (5) begin
      @(negedge clock);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    hold = 0;
    drain();

    while (mstk.size() < DEPTH) do_req(1'b1, $urandom);
    do_req(1'b1, $urandom);
    drain();
    while (mstk.size() > 0) do_req(1'b0, $urandom);
    do_req(1'b0, $urandom);
    drain();

    // Abort a pop from POP_WAIT
    do_req(1'b1, $urandom); drain();
    do_req(1'b0, $urandom);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sbq.delete();
    m_ovf = 0; m_udf = 0;
    #1;
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_sp_op", sp_op, 2'b00);
    chk("abort_sp", sp, 32'(BASE + mstk.size()));
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk("abort_no_rsp", rsp_valid, 1'b0);
    end

    repeat (150) do_req($urandom_range(0, 1) == 1, $urandom);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
